store_align_unit: RTL

- Sequential successor to the combinational store byte-enable decoder.
- Accepts one RISC-V S-type store (SB/SH/SW, plus SD when XLEN=64) from the execute stage and aligns its data to a parametrised-width data-memory port.
- Generates per-lane write enables and drives a request/acknowledge memory handshake.
- Splits a misaligned store that crosses a word boundary into two bus beats, or flags it as an error.
- Sits between the execute stage and the data-memory interface.

---
 rtl/store_align_unit_if.sv | 33 +++
 rtl/store_align_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/store_align_unit_if.sv
// Store-side and memory-side signals of the store alignment unit.
// The slave modport is the unit itself; the master modport is the surrounding pipeline and memory.
interface store_align_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  localparam int NB = XLEN / 8;

  logic              st_valid;
  logic              st_ready;
  logic [2:0]        st_funct3;
  logic [ADDR_W-1:0] st_addr;
  logic [XLEN-1:0]   st_wdata;
  logic              st_done;
  logic              st_err;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NB-1:0]     mem_be;
  logic [CNT_W-1:0]  split_cnt;

  modport slave (
    input  st_valid, st_funct3, st_addr, st_wdata, mem_ack,
    output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be, split_cnt
  );

  modport master (
    output st_valid, st_funct3, st_addr, st_wdata, mem_ack,
    input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be, split_cnt
  );
endinterface

// File: rtl/store_align_unit.sv
// Aligns one RISC-V store to the data-memory lanes and issues it as one or two
// request/ack beats, splitting stores that cross a bus-word boundary.
module store_align_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int CNT_W            = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  store_align_unit_if.slave   bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state_q;
  logic              st_ready_q, st_done_q, st_err_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [NB-1:0]     mem_be_q;
  logic [CNT_W-1:0]  split_cnt_q;
  logic              split_q;
  logic [ADDR_W-1:0] b1_addr_q;
  logic [XLEN-1:0]   b1_data_q;
  logic [NB-1:0]     b1_be_q;

  logic [OFFW-1:0]   off;
  logic [2*NB-1:0]   mask2;
  logic [2*NB-1:0]   be2;
  logic [2*XLEN-1:0] data2;
  logic [ADDR_W-1:0] base_addr;
  logic              legal;
  logic              split;

  // The byte mask and data are shifted into a double-width window so the
  // upper half directly gives the second beat of a boundary-crossing store.
  always_comb begin
    mask2 = '0;
    legal = 1'b1;
    case (bus.st_funct3)
      3'b000:  mask2 = (2*NB)'(8'h01);
      3'b001:  mask2 = (2*NB)'(8'h03);
      3'b010:  mask2 = (2*NB)'(8'h0F);
      3'b011: begin
        if (XLEN == 64) mask2 = (2*NB)'(8'hFF);
        else            legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  assign off       = bus.st_addr[OFFW-1:0];
  assign be2       = mask2 << off;
  assign data2     = {{XLEN{1'b0}}, bus.st_wdata} << {off, 3'b000};
  assign base_addr = {bus.st_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign split     = (be2[2*NB-1:NB] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      st_ready_q  <= 1'b0;
      st_done_q   <= 1'b0;
      st_err_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      split_cnt_q <= '0;
      split_q     <= 1'b0;
      b1_addr_q   <= '0;
      b1_data_q   <= '0;
      b1_be_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          st_ready_q <= 1'b1;
          if (bus.st_valid && st_ready_q) begin
            st_ready_q <= 1'b0;
            if (!legal || (split && !ALLOW_MISALIGNED)) begin
              state_q   <= RESP;
              st_done_q <= 1'b1;
              st_err_q  <= 1'b1;
            end else begin
              state_q     <= BEAT0;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= base_addr;
              mem_wdata_q <= data2[XLEN-1:0];
              mem_be_q    <= be2[NB-1:0];
              split_q     <= split;
              b1_addr_q   <= base_addr + ADDR_W'(NB);
              b1_data_q   <= data2[2*XLEN-1:XLEN];
              b1_be_q     <= be2[2*NB-1:NB];
            end
          end
        end
        BEAT0: begin
          if (mem_req_q && bus.mem_ack) begin
            if (split_q) begin
              state_q     <= BEAT1;
              mem_addr_q  <= b1_addr_q;
              mem_wdata_q <= b1_data_q;
              mem_be_q    <= b1_be_q;
              if (split_cnt_q != '1) split_cnt_q <= split_cnt_q + CNT_W'(1);
            end else begin
              state_q     <= RESP;
              mem_req_q   <= 1'b0;
              mem_wdata_q <= '0;
              mem_be_q    <= '0;
              st_done_q   <= 1'b1;
              st_err_q    <= 1'b0;
            end
          end
        end
        BEAT1: begin
          if (mem_req_q && bus.mem_ack) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            st_done_q   <= 1'b1;
            st_err_q    <= 1'b0;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          st_done_q  <= 1'b0;
          st_err_q   <= 1'b0;
          st_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.st_ready  = st_ready_q;
  assign bus.st_done   = st_done_q;
  assign bus.st_err    = st_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.split_cnt = split_cnt_q;
endmodule
